// File: rtl/registro_pkg.sv
// Shared definitions for the multi-mode register: operation encodings
// and the width of the mode select field.
package registro_pkg;

    localparam int MODO_W = 2;

    // Operation select values driven on the mode port
    typedef enum logic [MODO_W-1:0] {
        MODO_HOLD  = 2'b00,
        MODO_CARGA = 2'b01,
        MODO_IZQ   = 2'b10,
        MODO_DER   = 2'b11
    } modo_t;

endpackage

// File: rtl/registro_contador.sv
// Saturating up-counter used to count completed parallel loads.
// Once every bit is set it sticks there until reset.
module registro_contador #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    // Count up on each increment request unless already at the top value
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if (inc && !w_sat) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;
    assign sat = w_sat;

endmodule

// File: rtl/registro_multimodo.sv
// Multi-mode register: hold, parallel load, shift left, shift right,
// with a saturating count of completed loads.
// Optional feature: define REGISTRO_PARIDAD_EN to add the registered
// even-parity output par, tracking every value written into Q.
module registro_multimodo
    import registro_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [MODO_W-1:0] mode,
    input  logic [WIDTH-1:0]  L,
    input  logic              sin,
    output logic [WIDTH-1:0]  Q,
    output logic              sout,
    output logic [CNT_W-1:0]  load_cnt,
    output logic              cnt_sat
`ifdef REGISTRO_PARIDAD_EN
    ,
    output logic              par
`endif
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_qNext;
    logic             w_write;
    logic             w_loadInc;
    logic             w_sout;

    // Next data value for the selected operation; en low or HOLD keeps Q
    always_comb begin
        w_qNext = r_q;
        w_write = 1'b0;
        if (en) begin
            case (modo_t'(mode))
                MODO_CARGA: begin
                    w_qNext = L;
                    w_write = 1'b1;
                end
                MODO_IZQ: begin
                    w_qNext = {r_q[WIDTH-2:0], sin};
                    w_write = 1'b1;
                end
                MODO_DER: begin
                    w_qNext = {sin, r_q[WIDTH-1:1]};
                    w_write = 1'b1;
                end
                default: begin
                    w_qNext = r_q;
                    w_write = 1'b0;
                end
            endcase
        end
    end

    // Data register, cleared asynchronously so an aborted operation leaves nothing behind
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_q <= '0;
        end else if (w_write) begin
            r_q <= w_qNext;
        end
    end

    // Serial output follows the bit about to leave in the current shift direction, regardless of en
    always_comb begin
        w_sout = 1'b0;
        case (modo_t'(mode))
            MODO_IZQ: w_sout = r_q[WIDTH-1];
            MODO_DER: w_sout = r_q[0];
            default:  w_sout = 1'b0;
        endcase
    end

    assign w_loadInc = en && (modo_t'(mode) == MODO_CARGA);

    registro_contador #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clk (clk),
        .clr (clr),
        .inc (w_loadInc),
        .cnt (load_cnt),
        .sat (cnt_sat)
    );

`ifdef REGISTRO_PARIDAD_EN
    logic r_par;

    // Even parity bit of whatever is written into Q, stored alongside it
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_par <= 1'b0;
        end else if (w_write) begin
            r_par <= ^w_qNext;
        end
    end

    assign par = r_par;
`endif

    assign Q    = r_q;
    assign sout = w_sout;

endmodule

// File: tb/tb_registro_multimodo.sv
// Self-checking bench for registro_multimodo (WIDTH=12, CNT_W=4).
// Build with REGISTRO_PARIDAD_EN defined to also check the parity output.
module tb_registro_multimodo;

    localparam int WIDTH = 12;
    localparam int CNT_W = 4;

    logic             clk;
    logic             clr;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] L;
    logic             sin;
    logic [WIDTH-1:0] Q;
    logic             sout;
    logic [CNT_W-1:0] load_cnt;
    logic             cnt_sat;
`ifdef REGISTRO_PARIDAD_EN
    logic             par;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             en;
        logic [1:0]       mode;
        logic [WIDTH-1:0] L;
        logic             sin;
        logic             expSoutPre;
        logic [WIDTH-1:0] expQ;
        logic [CNT_W-1:0] expCnt;
        logic             expSat;
        logic             expPar;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [CNT_W-1:0] cnt;
        logic             sat;
        logic             par;
    } exp_t;

    exp_t scoreboard[$];
    vec_t vecs[10];

    registro_multimodo #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .mode     (mode),
        .L        (L),
        .sin      (sin),
        .Q        (Q),
        .sout     (sout),
        .load_cnt (load_cnt),
        .cnt_sat  (cnt_sat)
`ifdef REGISTRO_PARIDAD_EN
        ,
        .par      (par)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkNow(input string tag, input logic [WIDTH-1:0] q, input logic [CNT_W-1:0] cnt,
                            input logic sat, input logic p);
        checkOutput({tag, "_Q"}, 32'(Q), 32'(q));
        checkOutput({tag, "_cnt"}, 32'(load_cnt), 32'(cnt));
        checkOutput({tag, "_sat"}, 32'(cnt_sat), 32'(sat));
`ifdef REGISTRO_PARIDAD_EN
        checkOutput({tag, "_par"}, 32'(par), 32'(p));
`else
        if (p === 1'bx) $display("[TB] unexpected unknown parity expectation");
`endif
    endtask

    // Drive one operation at the falling edge, check sout before the rising
    // edge, queue the expected result and compare it after the edge.
    task automatic applyStimulus(input string tag, input logic e, input logic [1:0] m,
                                 input logic [WIDTH-1:0] l, input logic s, input logic expSout,
                                 input logic [WIDTH-1:0] q, input logic [CNT_W-1:0] cnt,
                                 input logic sat, input logic p);
        exp_t item;
        @(negedge clk);
        en   = e;
        mode = m;
        L    = l;
        sin  = s;
        #1;
        checkOutput({tag, "_sout"}, 32'(sout), 32'(expSout));
        item.q   = q;
        item.cnt = cnt;
        item.sat = sat;
        item.par = p;
        scoreboard.push_back(item);
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            item = scoreboard.pop_front();
            checkNow(tag, item.q, item.cnt, item.sat, item.par);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] mQ;
        logic [CNT_W-1:0] mCnt;
        logic [WIDTH-1:0] rnd;

        vecs[0] = '{1'b1, 2'b01, 12'h0C4, 1'b0, 1'b0, 12'h0C4, 4'd1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 2'b01, 12'hD11, 1'b0, 1'b0, 12'h0C4, 4'd1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 2'b10, 12'hFFF, 1'b1, 1'b0, 12'h0C4, 4'd1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 2'b00, 12'hFFF, 1'b1, 1'b0, 12'h0C4, 4'd1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 2'b01, 12'hD11, 1'b0, 1'b0, 12'hD11, 4'd2, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 2'b10, 12'h000, 1'b1, 1'b1, 12'hA23, 4'd2, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 2'b11, 12'h000, 1'b0, 1'b1, 12'h511, 4'd2, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 2'b11, 12'h000, 1'b1, 1'b1, 12'h511, 4'd2, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 2'b11, 12'h000, 1'b1, 1'b1, 12'hA88, 4'd2, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 2'b10, 12'h000, 1'b0, 1'b1, 12'h510, 4'd2, 1'b0, 1'b1};

        clr  = 1'b0;
        en   = 1'b0;
        mode = 2'b00;
        L    = '0;
        sin  = 1'b0;
        #3;
        checkNow("reset", 12'h000, 4'd0, 1'b0, 1'b0);
        #9;
        clr = 1'b1;

        // Asynchronous clear in the middle of a cycle, then clock edges ignored while low
        applyStimulus("preload", 1'b1, 2'b01, 12'hFFF, 1'b0, 1'b0, 12'hFFF, 4'd1, 1'b0, 1'b0);
        @(negedge clk);
        en   = 1'b1;
        mode = 2'b01;
        L    = 12'hABC;
        clr  = 1'b0;
        #1;
        checkNow("async_clr", 12'h000, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkNow("clr_held", 12'h000, 4'd0, 1'b0, 1'b0);
        en = 1'b0;
        @(negedge clk);
        clr = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].en, vecs[i].mode, vecs[i].L, vecs[i].sin,
                          vecs[i].expSoutPre, vecs[i].expQ, vecs[i].expCnt, vecs[i].expSat, vecs[i].expPar);
        end

        // Sixteen loads from a cleared counter: it climbs to 15 and then sticks
        doReset();
        mCnt = '0;
        mQ   = '0;
        for (int i = 0; i < 16; i++) begin
            rnd  = WIDTH'($urandom_range(0, 4095));
            mQ   = rnd;
            mCnt = (mCnt == 4'd15) ? mCnt : mCnt + 4'd1;
            applyStimulus($sformatf("sat_load%0d", i), 1'b1, 2'b01, rnd, 1'b0, 1'b0,
                          mQ, mCnt, (mCnt == 4'd15), ^mQ);
        end
        applyStimulus("sat_795", 1'b1, 2'b01, 12'h795, 1'b0, 1'b0, 12'h795, 4'd15, 1'b1, 1'b1);
        applyStimulus("sat_0C4", 1'b1, 2'b01, 12'h0C4, 1'b0, 1'b0, 12'h0C4, 4'd15, 1'b1, 1'b1);
        applyStimulus("sat_0C5", 1'b1, 2'b01, 12'h0C5, 1'b0, 1'b0, 12'h0C5, 4'd15, 1'b1, 1'b0);
        applyStimulus("sat_shl", 1'b1, 2'b10, 12'h000, 1'b0, 1'b0, 12'h18A, 4'd15, 1'b1, 1'b0);

        // Clear pulsed low across an active load edge leaves nothing behind
        @(negedge clk);
        en   = 1'b1;
        mode = 2'b01;
        L    = 12'hABC;
        #2;
        clr = 1'b0;
        @(posedge clk);
        #2;
        clr = 1'b1;
        en  = 1'b0;
        #1;
        checkNow("clr_pulse", 12'h000, 4'd0, 1'b0, 1'b0);

        // First enabled edge after release performs the operation
        applyStimulus("post_clr", 1'b1, 2'b01, 12'h3C3, 1'b0, 1'b0, 12'h3C3, 4'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
